multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencer for the processor datapath: replaces single-cycle decode with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath muxes, register-file and memory strobes, stalls on a memory ready handshake, and counts retired instructions. It sits between the instruction register opcode field and the shared PC/ALU/register-file/memory datapath.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in  in  8  opcode field of instruction register; valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if branch condition true
- branch_ne  out  1  branch condition is "not equal" (bne), else "equal"
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data = memory data register
- regdest  out  1  destination = rd (1) / rt (0)
- regwrite  out  1  register file write enable
- link  out  1  write PC to link register (overrides regdest/memtoreg)
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 rt, 01 constant 1, 10 sign-ext imm, 11 branch offset
- aluop  out  2  00 add, 01 subtract, 10 funct-decoded
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- instr_done  out  1  one-cycle pulse on final state of each instruction
- illegal  out  1  sticky: undefined opcode decoded
- retired  out  CNT_W  count of completed instructions

## Operation
- Opcodes: rtype 0x29, lw 0x2A, sw 0x2B, beq 0x2C, bne 0x2D, addi 0x2E, j 0x2F, jf 0x30; any other value is illegal.
- States and transitions:
  - IDLE → FETCH.
  - FETCH → DECODE when mem_ready.
  - DECODE dispatches by opcode: lw/sw → MEM_ADDR; rtype → EXEC_R; addi → EXEC_I; beq/bne → BRANCH; j → JUMP; jf → JF; other → HALT.
  - MEM_ADDR → MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ → MEM_WB on mem_ready.
  - MEM_WRITE → FETCH on mem_ready.
  - EXEC_R → R_WB; EXEC_I → I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH, JUMP, JF → FETCH.
  - HALT holds until rst.
- Outputs per state (unlisted outputs 0):
  - IDLE / HALT: all 0; illegal=1 in HALT.
  - FETCH: memread, iord=0, alusrcb=01, aluop=00, pcsource=00; irwrite and pcwrite equal mem_ready.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEM_ADDR / EXEC_I: alusrca=1, alusrcb=10, aluop=00.
  - MEM_READ: memread, iord=1.
  - MEM_WRITE: memwrite, iord=1.
  - MEM_WB: regwrite, memtoreg=1.
  - EXEC_R: alusrca=1, alusrcb=00, aluop=10.
  - R_WB: regwrite, regdest=1.
  - I_WB: regwrite.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsource=01, branch_ne=(in==0x2D).
  - JUMP: pcwrite, pcsource=10.
  - JF: pcwrite, pcsource=10, regwrite, link.
- instr_done=1 in the final state of each instruction: MEM_WB, R_WB, I_WB, BRANCH, JUMP, JF, and MEM_WRITE when mem_ready.
- retired increments by 1 on each instr_done and wraps modulo 2^CNT_W.

## Timing
- Reset: state=IDLE, every output 0, retired=0, illegal=0. Reset mid-instruction aborts it with no further strobes.
- Outputs are decoded from the registered state. The only exceptions are irwrite/pcwrite in FETCH and instr_done in MEM_WRITE, which are gated by mem_ready.
- Latency with mem_ready constantly 1:
  - lw 5 cycles.
  - sw, rtype, addi 4 cycles.
  - beq, bne, j, jf 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle; all strobes hold steady while stalled.
- in is sampled only in DECODE and BRANCH.

## Structure
- Shared package mc_pkg holds:
  - the opcode constants;
  - the state enum;
  - the alusrcb, aluop and pcsource encodings.
- One sub-module, opcode_decode: combinational opcode → one-hot class (rtype, lw, sw, beq, bne, addi, j, jf, illegal).

## Test plan
- rtype 0x29, mem_ready=1 → FETCH, DECODE, EXEC_R, R_WB; regwrite=regdest=1 on cycle 4; retired 0→1.
- lw 0x2A, mem_ready low 2 cycles in MEM_READ → 7 cycles total; memread held 3 cycles with iord=1; memtoreg=regwrite=1 in MEM_WB.
- bne 0x2D → BRANCH on cycle 3 with pcwritecond=1, branch_ne=1, aluop=01; beq 0x2C → branch_ne=0.
- jf 0x30 → JF on cycle 3 with pcwrite, regwrite and link all 1, pcsource=10; then next FETCH.
- Opcode 0x31 → HALT; illegal=1 and all strobes 0 indefinitely; rst clears illegal and returns to IDLE.
- rst asserted during MEM_WRITE with mem_ready=0 → memwrite drops immediately, retired=0; CNT_W=4 with 16 instructions → retired wraps to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes,
// FSM state encoding, datapath mux encodings and the decoded opcode class.
package mc_pkg;

  localparam logic [7:0] OP_RTYPE = 8'h29;
  localparam logic [7:0] OP_LW    = 8'h2A;
  localparam logic [7:0] OP_SW    = 8'h2B;
  localparam logic [7:0] OP_BEQ   = 8'h2C;
  localparam logic [7:0] OP_BNE   = 8'h2D;
  localparam logic [7:0] OP_ADDI  = 8'h2E;
  localparam logic [7:0] OP_J     = 8'h2F;
  localparam logic [7:0] OP_JF    = 8'h30;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WRITE,
    S_MEM_WB,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JF,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    SRCB_RT   = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BOFS = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsource_e;

  // One-hot instruction class produced by opcode_decode.
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic addi;
    logic j;
    logic jf;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/handshake inputs and datapath control strobes of the sequencer.
// master: the control FSM side; slave: the datapath side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [7:0]       in;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             branch_ne;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdest;
  logic             regwrite;
  logic             link;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  in, mem_ready,
    output pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
           memtoreg, regdest, regwrite, link, alusrca, alusrcb, aluop,
           pcsource, instr_done, illegal, retired
  );

  modport slave (
    output in, mem_ready,
    input  pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
           memtoreg, regdest, regwrite, link, alusrca, alusrcb, aluop,
           pcsource, instr_done, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode to one-hot instruction class; anything outside the
// defined opcode set is flagged illegal.
module opcode_decode
  import mc_pkg::*;
(
  input  logic [7:0] op_i,
  output op_class_t  cls_o
);

  // Map the opcode field onto exactly one class bit.
  always_comb begin
    cls_o = '0;
    unique case (op_i)
      OP_RTYPE: cls_o.rtype   = 1'b1;
      OP_LW:    cls_o.lw      = 1'b1;
      OP_SW:    cls_o.sw      = 1'b1;
      OP_BEQ:   cls_o.beq     = 1'b1;
      OP_BNE:   cls_o.bne     = 1'b1;
      OP_ADDI:  cls_o.addi    = 1'b1;
      OP_J:     cls_o.j       = 1'b1;
      OP_JF:    cls_o.jf      = 1'b1;
      default:  cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: Moore FSM stepping each instruction
// through fetch/decode/execute/memory/write-back, with memory stalls and a
// retired-instruction counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset, one cycle before the first fetch
// FETCH     | read instruction at PC, load IR and PC+1 on mem_ready
// DECODE    | compute branch target, dispatch on opcode
// MEM_ADDR  | compute rs + imm address for lw/sw
// MEM_READ  | read data memory, wait for mem_ready
// MEM_WRITE | write data memory, wait for mem_ready (sw completes)
// MEM_WB    | write loaded data to rt (lw completes)
// EXEC_R    | ALU rs op rt, funct-decoded
// R_WB      | write ALU result to rd (rtype completes)
// EXEC_I    | ALU rs + imm
// I_WB      | write ALU result to rt (addi completes)
// BRANCH    | compare rs/rt, conditionally load PC (beq/bne complete)
// JUMP      | load jump target (j completes)
// JF        | load jump target and write link register (jf completes)
// HALT      | illegal opcode seen, hold until reset
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  op_class_t        cls;
  logic             is_lw_q;
  logic             illegal_q;
  logic             done;
  logic [CNT_W-1:0] retired_q;

  opcode_decode u_opcode_decode (
    .op_i  (bus.in),
    .cls_o (cls)
  );

  // State register plus the lw/sw choice captured at decode, so the
  // opcode field is not needed again in MEM_ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_lw_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_lw_q <= cls.lw;
      if (state_d == S_HALT) illegal_q <= 1'b1;
      if (done) retired_q <= retired_q + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (cls.lw || cls.sw)        state_d = S_MEM_ADDR;
        else if (cls.rtype)          state_d = S_EXEC_R;
        else if (cls.addi)           state_d = S_EXEC_I;
        else if (cls.beq || cls.bne) state_d = S_BRANCH;
        else if (cls.j)              state_d = S_JUMP;
        else if (cls.jf)             state_d = S_JF;
        else                         state_d = S_HALT;
      end
      S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JF:
                   state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Moore output decode; only FETCH and MEM_WRITE look at mem_ready.
  always_comb begin
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.branch_ne   = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdest     = 1'b0;
    bus.regwrite    = 1'b0;
    bus.link        = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = SRCB_RT;
    bus.aluop       = ALUOP_ADD;
    bus.pcsource    = PCSRC_ALU;
    done            = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = SRCB_ONE;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      S_DECODE:  bus.alusrcb = SRCB_BOFS;
      S_MEM_ADDR, S_EXEC_I: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEM_READ: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        done         = bus.mem_ready;
      end
      S_MEM_WB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        done         = 1'b1;
      end
      S_EXEC_R: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        bus.regwrite = 1'b1;
        bus.regdest  = 1'b1;
        done         = 1'b1;
      end
      S_I_WB: begin
        bus.regwrite = 1'b1;
        done         = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluop       = ALUOP_SUB;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = PCSRC_ALUOUT;
        bus.branch_ne   = cls.bne;
        done            = 1'b1;
      end
      S_JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = PCSRC_JUMP;
        done         = 1'b1;
      end
      S_JF: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = PCSRC_JUMP;
        bus.regwrite = 1'b1;
        bus.link     = 1'b1;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_done = done;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule
